// File: rtl/simd_add_pkg.sv
// simd_add_pkg: shared defaults, width codes and lane-group mask helpers
// for the SIMD saturating adder.
//   LANE_W_DEF / NLANES_DEF / MODE_W_DEF : default geometry
//   W_LANE / W_PAIR / W_FULL             : group size codes for the 4-lane default
//   group_first_mask(lg) / group_last_mask(lg) : lane masks for groups of 2**lg lanes
package simd_add_pkg;

  localparam int LANE_W_DEF = 8;
  localparam int NLANES_DEF = 4;
  localparam int MODE_W_DEF = 2;

  // Masks are built this wide and truncated by the caller to NLANES bits.
  localparam int MAX_LANES  = 64;

  localparam logic [MODE_W_DEF-1:0] W_LANE = 2'd0;
  localparam logic [MODE_W_DEF-1:0] W_PAIR = 2'd1;
  localparam logic [MODE_W_DEF-1:0] W_FULL = 2'd2;

  // Bit i set when lane i is the lowest lane of its group (carry-in is cut).
  function automatic logic [MAX_LANES-1:0] group_first_mask(input int lg);
    logic [MAX_LANES-1:0] m;
    int gm;
    m  = '0;
    gm = (1 << lg) - 1;
    for (int i = 0; i < MAX_LANES; i++) m[i] = ((i & gm) == 0);
    return m;
  endfunction

  // Bit i set when lane i is the top lane of its group (holds sign/carry).
  function automatic logic [MAX_LANES-1:0] group_last_mask(input int lg);
    logic [MAX_LANES-1:0] m;
    int gm;
    m  = '0;
    gm = (1 << lg) - 1;
    for (int i = 0; i < MAX_LANES; i++) m[i] = ((i & gm) == gm);
    return m;
  endfunction

endpackage

// File: rtl/simd_lane_ctrl.sv
// simd_lane_ctrl: combinational per-lane group control.
//   i_width   : group size code (2**i_width lanes, clamped to full width)
//   i_signed  : select two's-complement overflow rule
//   i_cout, i_a_msb, i_b_msb, i_s_msb : per-lane carry out and operand/sum MSBs
//   o_grp_first : lane starts a group (its carry-in is forced to 0)
//   o_sat_last  : lane is top of its group (gets the 7F/80 byte when saturating)
//   o_ovf       : group overflow replicated to every lane of the group
//   o_sat_sign  : group-top A sign replicated (1 -> saturate to min)
module simd_lane_ctrl
  import simd_add_pkg::*;
#(
  parameter int NLANES = NLANES_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic [MODE_W-1:0] i_width,
  input  logic              i_signed,
  input  logic [NLANES-1:0] i_cout,
  input  logic [NLANES-1:0] i_a_msb,
  input  logic [NLANES-1:0] i_b_msb,
  input  logic [NLANES-1:0] i_s_msb,
  output logic [NLANES-1:0] o_grp_first,
  output logic [NLANES-1:0] o_sat_last,
  output logic [NLANES-1:0] o_ovf,
  output logic [NLANES-1:0] o_sat_sign
);

  localparam int LG_MAX = $clog2(NLANES);
  localparam int IDX_W  = (LG_MAX < 1) ? 1 : LG_MAX;

  int               w_lg;
  logic [IDX_W-1:0] w_gmask;

  assign w_lg    = (int'(i_width) > LG_MAX) ? LG_MAX : int'(i_width);
  assign w_gmask = IDX_W'((1 << w_lg) - 1);

  // Masks depend only on width; kept apart from the overflow logic so the
  // carry chain in the parent never sees a combinational loop.
  assign o_grp_first = NLANES'(group_first_mask(w_lg));
  assign o_sat_last  = NLANES'(group_last_mask(w_lg));

  always_comb begin
    logic [IDX_W-1:0] top;
    o_ovf      = '0;
    o_sat_sign = '0;
    top        = '0;
    for (int i = 0; i < NLANES; i++) begin
      // Top lane of lane i's group: set all in-group index bits.
      top           = IDX_W'(i) | w_gmask;
      o_ovf[i]      = i_signed ? ((i_a_msb[top] == i_b_msb[top]) && (i_s_msb[top] != i_a_msb[top]))
                               : i_cout[top];
      o_sat_sign[i] = i_a_msb[top];
    end
  end

endmodule

// File: rtl/simd_sat_pipe_adder.sv
// simd_sat_pipe_adder: 2-stage SIMD adder/accumulator with lane grouping,
// overflow detection, optional saturation and sticky overflow flags.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake
//   in_a, in_b            : operands, lane i = bits [i*LANE_W +: LANE_W]
//   in_width/signed/sat/acc : per-transaction mode
//   acc_clr, sticky_clr   : accumulator / sticky clear
//   out_valid/out_ready   : result handshake
//   out_sum, out_ovf, out_sticky : result, per-lane overflow, sticky OR
module simd_sat_pipe_adder
  import simd_add_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF,
  parameter int NLANES = NLANES_DEF,
  parameter int MODE_W = MODE_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*LANE_W-1:0] in_a,
  input  logic [NLANES*LANE_W-1:0] in_b,
  input  logic [MODE_W-1:0]        in_width,
  input  logic                     in_signed,
  input  logic                     in_sat,
  input  logic                     in_acc,
  input  logic                     acc_clr,
  input  logic                     sticky_clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NLANES*LANE_W-1:0] out_sum,
  output logic [NLANES-1:0]        out_ovf,
  output logic [NLANES-1:0]        out_sticky
);

  // S0: operand register
  logic                           r_s0_vld;
  logic [NLANES-1:0][LANE_W-1:0]  r_s0_a, r_s0_b;
  logic [MODE_W-1:0]              r_s0_width;
  logic                           r_s0_signed, r_s0_sat, r_s0_acc;
  // S1: result register and side state
  logic                           r_s1_vld;
  logic [NLANES-1:0][LANE_W-1:0]  r_sum, r_acc;
  logic [NLANES-1:0]              r_ovf, r_sticky;

  logic                           w_s1_load, w_s0_move;
  logic [NLANES-1:0][LANE_W-1:0]  w_b, w_sum, w_res;
  logic [NLANES-1:0]              w_cout, w_a_msb, w_b_msb, w_s_msb;
  logic [NLANES-1:0]              w_grp_first, w_sat_last, w_ovf, w_sat_sign;

  assign w_s1_load = !r_s1_vld || out_ready;
  assign w_s0_move = r_s0_vld && w_s1_load;
  assign in_ready  = !r_s0_vld || w_s1_load;

  // Lane adders with the carry chain cut at group boundaries.
  always_comb begin
    logic c, cin;
    c       = 1'b0;
    cin     = 1'b0;
    w_b     = r_s0_acc ? r_acc : r_s0_b;
    w_sum   = '0;
    w_cout  = '0;
    w_a_msb = '0;
    w_b_msb = '0;
    w_s_msb = '0;
    for (int i = 0; i < NLANES; i++) begin
      cin         = w_grp_first[i] ? 1'b0 : c;
      {c, w_sum[i]} = {1'b0, r_s0_a[i]} + {1'b0, w_b[i]} + (LANE_W+1)'(cin);
      w_cout[i]   = c;
      w_a_msb[i]  = r_s0_a[i][LANE_W-1];
      w_b_msb[i]  = w_b[i][LANE_W-1];
      w_s_msb[i]  = w_sum[i][LANE_W-1];
    end
  end

  simd_lane_ctrl #(.NLANES(NLANES), .MODE_W(MODE_W)) u_ctrl (
    .i_width     (r_s0_width),
    .i_signed    (r_s0_signed),
    .i_cout      (w_cout),
    .i_a_msb     (w_a_msb),
    .i_b_msb     (w_b_msb),
    .i_s_msb     (w_s_msb),
    .o_grp_first (w_grp_first),
    .o_sat_last  (w_sat_last),
    .o_ovf       (w_ovf),
    .o_sat_sign  (w_sat_sign)
  );

  // Saturation: signed groups clamp to 80..00 / 7F..FF with the sign byte on
  // the group top lane; unsigned groups clamp to all ones.
  always_comb begin
    w_res = w_sum;
    for (int i = 0; i < NLANES; i++) begin
      if (r_s0_sat && w_ovf[i]) begin
        if (r_s0_signed) begin
          if (w_sat_sign[i]) w_res[i] = w_sat_last[i] ? {1'b1, {(LANE_W-1){1'b0}}} : '0;
          else               w_res[i] = w_sat_last[i] ? {1'b0, {(LANE_W-1){1'b1}}} : '1;
        end else begin
          w_res[i] = '1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s0_vld    <= 1'b0;
      r_s0_a      <= '0;
      r_s0_b      <= '0;
      r_s0_width  <= '0;
      r_s0_signed <= 1'b0;
      r_s0_sat    <= 1'b0;
      r_s0_acc    <= 1'b0;
      r_s1_vld    <= 1'b0;
      r_sum       <= '0;
      r_ovf       <= '0;
      r_sticky    <= '0;
      r_acc       <= '0;
    end else begin
      if (in_ready) begin
        r_s0_vld <= in_valid;
        if (in_valid) begin
          r_s0_a      <= in_a;
          r_s0_b      <= in_b;
          r_s0_width  <= in_width;
          r_s0_signed <= in_signed;
          r_s0_sat    <= in_sat;
          r_s0_acc    <= in_acc;
        end
      end
      if (w_s1_load) begin
        r_s1_vld <= r_s0_vld;
        if (r_s0_vld) begin
          r_sum <= w_res;
          r_ovf <= w_ovf;
        end
      end
      // A set on the same edge as a clear survives.
      r_sticky <= (sticky_clr ? '0 : r_sticky) | (w_s0_move ? w_ovf : '0);
      // Written as the op leaves S0, so the next op in S0 already sees it.
      if (acc_clr)                    r_acc <= '0;
      else if (w_s0_move && r_s0_acc) r_acc <= w_res;
    end
  end

  assign out_valid  = r_s1_vld;
  assign out_sum    = r_sum;
  assign out_ovf    = r_ovf;
  assign out_sticky = r_sticky;

endmodule
